pkt_drop_buffer: RTL

//  Output stage after pkt_assembler: buffers assembled SpiNNaker multicast packets ahead of the HSSL mux.

---
 rtl/pkt_drop_buffer_pkg.sv | 37 +++
 rtl/pkt_drop_buffer_fifo.sv | 64 ++++++
 rtl/pkt_drop_buffer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pkt_drop_buffer_pkg.sv
// Shared constants and helpers for the SpiNNaker packet drop buffer.
// Packet layout, reg bank indices and saturating counter update.
package pkt_drop_buffer_pkg;

    localparam int PKT_BITS      = 72;
    localparam int PARITY_IDX    = 0;
    localparam int HDR_LSB       = 0;
    localparam int KEY_LSB       = 8;
    localparam int PAYLOAD_LSB   = 40;
    localparam int BUF_LOG_DEF   = 3;
    localparam int WAIT_BITS_DEF = 16;
    localparam int CNT_BITS      = 32;

    typedef enum logic [1:0] {
        REG_DROP_WAIT = 2'd0,
        REG_CNT_SENT  = 2'd1,
        REG_CNT_DROP  = 2'd2,
        REG_CNT_PERR  = 2'd3
    } reg_idx_e;

    // Clear beats increment; increment saturates at all-ones.
    function automatic logic [CNT_BITS-1:0] cnt_upd(
        input logic [CNT_BITS-1:0] q,
        input logic                inc,
        input logic                clr
    );
        logic [CNT_BITS-1:0] r;
        r = q;
        if (clr) begin
            r = '0;
        end else if (inc && (q != '1)) begin
            r = q + CNT_BITS'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/pkt_drop_buffer_fifo.sv
// Synchronous FIFO holding packets behind the output register.
// Pointers wrap modulo the depth; a separate count tracks occupancy.
module pkt_fifo
    import pkt_drop_buffer_pkg::*;
#(
    parameter int WIDTH = PKT_BITS,
    parameter int LOG   = BUF_LOG_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LOG:0]     count_o
);

    localparam int DEPTH = 2 ** LOG;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LOG-1:0]   wr_ptr_q;
    logic [LOG-1:0]   rd_ptr_q;
    logic [LOG:0]     count_q;
    logic [LOG:0]     count_d;

    always_comb begin
        count_d = count_q;
        unique case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + (LOG+1)'(1);
            2'b01:   count_d = count_q - (LOG+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + LOG'(1);
            end
            if (rd_en_i) begin
                rd_ptr_q <= rd_ptr_q + LOG'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (LOG+1)'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/pkt_drop_buffer.sv
// Output buffer ahead of the HSSL mux: parity filter, FIFO, output
// register, stall-timeout head drop and saturating statistics counters.
module pkt_drop_buffer
    import pkt_drop_buffer_pkg::*;
#(
    parameter int PACKET_BITS = PKT_BITS,
    parameter int BUF_LOG     = BUF_LOG_DEF,
    parameter int WAIT_BITS   = WAIT_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WAIT_BITS-1:0]   drop_wait_in,
    input  logic                   cnt_clr_in,
    input  logic [PACKET_BITS-1:0] pkt_data_in,
    input  logic                   pkt_vld_in,
    output logic                   pkt_rdy_out,
    output logic [PACKET_BITS-1:0] pkt_data_out,
    output logic                   pkt_vld_out,
    input  logic                   pkt_rdy_in,
    output logic [CNT_BITS-1:0]    cnt_sent_out,
    output logic [CNT_BITS-1:0]    cnt_drop_out,
    output logic [CNT_BITS-1:0]    cnt_perr_out
);

    localparam logic [BUF_LOG:0] DEPTH = (BUF_LOG+1)'(2 ** BUF_LOG);

    logic                   rdy_q,  rdy_d;
    logic                   vld_q,  vld_d;
    logic [PACKET_BITS-1:0] data_q, data_d;
    logic                   load;
    logic [WAIT_BITS-1:0]   stall_q, stall_d;
    logic [CNT_BITS-1:0]    sent_q, sent_d;
    logic [CNT_BITS-1:0]    drop_q, drop_d;
    logic [CNT_BITS-1:0]    perr_q, perr_d;

    logic                   good;
    logic                   accept;
    logic                   xfer;
    logic                   stalled;
    logic                   drop;
    logic                   out_free;
    logic                   bypass;
    logic [WAIT_BITS:0]     stall_p1;

    logic                   fifo_wr;
    logic                   fifo_rd;
    logic [PACKET_BITS-1:0] fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [BUF_LOG:0]       fifo_cnt;
    logic [BUF_LOG:0]       fifo_cnt_d;

    pkt_fifo #(
        .WIDTH (PACKET_BITS),
        .LOG   (BUF_LOG)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (fifo_wr),
        .wr_data_i (pkt_data_in),
        .rd_en_i   (fifo_rd),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt)
    );

    always_comb begin
        good     = ^pkt_data_in;
        accept   = pkt_vld_in && rdy_q;
        xfer     = vld_q && pkt_rdy_in;
        stalled  = vld_q && !pkt_rdy_in;
        stall_p1 = {1'b0, stall_q} + (WAIT_BITS+1)'(1);
        drop     = stalled && (drop_wait_in != '0)
                   && (stall_p1 >= {1'b0, drop_wait_in});
        out_free = !vld_q || xfer || drop;
        // The FIFO head always has priority over a bypassing input.
        fifo_rd  = out_free && !fifo_empty;
        bypass   = accept && good && out_free && fifo_empty;
        fifo_wr  = accept && good && !bypass && !fifo_full;
    end

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        load   = 1'b0;
        if (fifo_rd) begin
            vld_d  = 1'b1;
            data_d = fifo_head;
            load   = 1'b1;
        end else if (bypass) begin
            vld_d  = 1'b1;
            data_d = pkt_data_in;
            load   = 1'b1;
        end else if (out_free) begin
            vld_d  = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!vld_q || xfer || drop) begin
            stall_d = '0;
        end else if (stall_q != '1) begin
            stall_d = stall_q + WAIT_BITS'(1);
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt
                     + (BUF_LOG+1)'(fifo_wr)
                     - (BUF_LOG+1)'(fifo_rd);
        rdy_d      = (fifo_cnt_d != DEPTH);
    end

    always_comb begin
        sent_d = cnt_upd(sent_q, xfer, cnt_clr_in);
        drop_d = cnt_upd(drop_q, drop, cnt_clr_in);
        perr_d = cnt_upd(perr_q, accept && !good, cnt_clr_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            stall_q <= '0;
            sent_q  <= '0;
            drop_q  <= '0;
            perr_q  <= '0;
        end else begin
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            stall_q <= stall_d;
            sent_q  <= sent_d;
            drop_q  <= drop_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= data_d;
        end
    end

    assign pkt_rdy_out  = rdy_q;
    assign pkt_vld_out  = vld_q;
    assign pkt_data_out = data_q;
    assign cnt_sent_out = sent_q;
    assign cnt_drop_out = drop_q;
    assign cnt_perr_out = perr_q;

endmodule
